// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-stage definitions: bubble encoding, reset PC, fetch FSM states
// and the word/PC pair carried through the skid and IF/ID registers.
package instruction_fetch_pkg;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;  // addi x0,x0,0

    // A bubble in any pipeline register is NOP with valid cleared.
    localparam logic BUBBLE_VALID = 1'b0;
    localparam logic WORD_VALID   = 1'b1;

    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_WAIT  = 3'd1,
        ST_HOLD  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_HALT  = 3'd4
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_word_t;

    // Sequential PC step; wraps mod 2^32 by construction.
    function automatic logic [31:0] next_word_addr(input logic [31:0] addr);
        return addr + 32'd4;
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction-memory request/grant/response bundle.
interface instruction_fetch_if;

    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata
    );

endinterface

// File: rtl/instruction_fetch_if_id_register.sv
// IF/ID pipeline register. Flush beats stall; an idle non-stalled cycle
// loads a bubble. PC fields are left untouched by bubbles and flushes since
// they only carry meaning alongside a valid instruction.
module if_id_register
    import instruction_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        load,
    input  fetch_word_t word,
    output logic [31:0] instruction,
    output logic [31:0] pc,
    output logic [31:0] pc_plus_4,
    output logic        valid
);

    // Register update: reset, flush, hold on stall, else load word or bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instruction <= NOP;
            pc          <= 32'h0000_0000;
            pc_plus_4   <= 32'h0000_0004;
            valid       <= BUBBLE_VALID;
        end else if (flush) begin
            instruction <= NOP;
            valid       <= BUBBLE_VALID;
        end else if (!stall) begin
            if (load) begin
                instruction <= word.instr;
                pc          <= word.pc;
                pc_plus_4   <= next_word_addr(word.pc);
                valid       <= WORD_VALID;
            end else begin
                instruction <= NOP;
                valid       <= BUBBLE_VALID;
            end
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, keeps at most one fetch outstanding,
// absorbs a stall with a one-entry skid and kills fetches on EX redirects.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_FETCH | request pc, waiting for grant
//   ST_WAIT  | one fetch outstanding, waiting for its response
//   ST_HOLD  | response parked in skid while ID is stalled
//   ST_DRAIN | outstanding fetch was killed; drop its response
//   ST_HALT  | misaligned redirect seen; idle until reset
module instruction_fetch
    import instruction_fetch_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    instruction_fetch_if.master   imem,
    input  logic                  stall,
    input  logic                  redirect,
    input  logic [31:0]           redirect_pc,
    output logic [31:0]           if_id_instruction,
    output logic [31:0]           if_id_pc,
    output logic [31:0]           if_id_pc_plus_4,
    output logic                  if_id_valid,
    output logic                  fetch_fault
);

    fetch_state_e state, state_n;
    logic [31:0]  pc, pc_n;
    logic [31:0]  inflight_pc, inflight_pc_n;
    fetch_word_t  skid, skid_n;
    logic         skid_valid, skid_valid_n;
    logic         fault_n;
    logic         req;
    logic         deliver;
    fetch_word_t  deliver_word;
    logic         flush;
    logic         target_misaligned;

    assign target_misaligned = (redirect_pc[1:0] != 2'b00);

    // Request is suppressed during reset; the address is always the PC register.
    assign imem.req  = req & rst_n;
    assign imem.addr = pc;

    // Next-state, request and IF/ID delivery decode.
    always_comb begin
        state_n       = state;
        pc_n          = pc;
        inflight_pc_n = inflight_pc;
        skid_n        = skid;
        skid_valid_n  = skid_valid;
        fault_n       = fetch_fault;
        req           = 1'b0;
        deliver       = 1'b0;
        deliver_word  = '0;
        flush         = 1'b0;

        if (state == ST_HALT) begin
            state_n = ST_HALT;
        end else if (redirect) begin
            flush        = 1'b1;
            skid_n       = '0;
            skid_valid_n = 1'b0;
            if (target_misaligned) begin
                fault_n = 1'b1;
                state_n = ST_HALT;
            end else begin
                pc_n = redirect_pc;
                // A fetch still in flight must have its response dropped.
                if ((state == ST_WAIT || state == ST_DRAIN) && !imem.rvalid) begin
                    state_n = ST_DRAIN;
                end else begin
                    state_n = ST_FETCH;
                end
            end
        end else begin
            case (state)
                ST_FETCH: begin
                    req = 1'b1;
                    if (imem.gnt) begin
                        inflight_pc_n = pc;
                        pc_n          = next_word_addr(pc);
                        state_n       = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem.rvalid) begin
                        if (!stall) begin
                            deliver            = 1'b1;
                            deliver_word.instr = imem.rdata;
                            deliver_word.pc    = inflight_pc;
                            // Back-to-back request keeps one instruction per cycle.
                            req = 1'b1;
                            if (imem.gnt) begin
                                inflight_pc_n = pc;
                                pc_n          = next_word_addr(pc);
                                state_n       = ST_WAIT;
                            end else begin
                                state_n = ST_FETCH;
                            end
                        end else begin
                            skid_n.instr = imem.rdata;
                            skid_n.pc    = inflight_pc;
                            skid_valid_n = 1'b1;
                            state_n      = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        deliver      = skid_valid;
                        deliver_word = skid;
                        skid_valid_n = 1'b0;
                        state_n      = ST_FETCH;
                    end
                end
                ST_DRAIN: begin
                    if (imem.rvalid) begin
                        state_n = ST_FETCH;
                    end
                end
                default: begin
                    state_n = ST_HALT;
                end
            endcase
        end
    end

    // Fetch state, PC, in-flight PC, skid and fault registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_FETCH;
            pc          <= RESET_PC;
            inflight_pc <= RESET_PC;
            skid        <= '0;
            skid_valid  <= 1'b0;
            fetch_fault <= 1'b0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            inflight_pc <= inflight_pc_n;
            skid        <= skid_n;
            skid_valid  <= skid_valid_n;
            fetch_fault <= fault_n;
        end
    end

    if_id_register u_if_id (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .flush       (flush),
        .load        (deliver),
        .word        (deliver_word),
        .instruction (if_id_instruction),
        .pc          (if_id_pc),
        .pc_plus_4   (if_id_pc_plus_4),
        .valid       (if_id_valid)
    );

endmodule
